// File: rtl/fads_pkg.sv
// Shared definitions for the FADS sort-trigger consumer.
//   - FSM state encoding
//   - default timer (TW) and counter (CW) widths
//   - saturating increment helper used by the event counters
package fads_pkg;

  localparam int TW_DEF = 24;
  localparam int CW_DEF = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DELAY   = 2'd1;
  localparam logic [1:0] ST_PULSE   = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  // Works on a 64-bit carrier so any counter width up to 64 can share it;
  // callers pass their own all-ones ceiling and truncate the result.
  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input logic [63:0] max_val);
    return (val >= max_val) ? max_val : val + 64'd1;
  endfunction

endpackage

// File: rtl/fads_down_timer.sv
// Loadable down-counter shared by all timed FSM states.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   load       load load_val (has priority over en)
//   en         decrement by one, stopping at zero
//   load_val   reload value
//   zero       count is zero
module fads_down_timer
  import fads_pkg::*;
#(
  parameter int TW = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '0))
      count <= count - TW'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/red_pitaya_fads_sorter.sv
// FADS sort trigger consumer: turns the detector trigger level into one
// delayed actuation window with a start strobe for the ASG, followed by a
// dead time. Everything runs on the ADC clock.
//
// Build option: FADS_MISS_CNT_EN -- when defined, triggers dropped while busy
// are counted on miss_cnt_o; otherwise miss_cnt_o is tied to zero.
//
// Ports:
//   adc_clk_i, adc_rst_i       clock, asynchronous active-high reset
//   sort_trig_i                detector trigger level
//   enable_i                   sorter enable (low aborts to IDLE)
//   delay_i, width_i, holdoff_i timing config, latched on acceptance
//   clr_cnt_i                  synchronous clear of both counters
//   asg_trig_o                 1-cycle strobe on first window cycle
//   sort_gate_o                actuation window
//   busy_o                     not IDLE
//   sort_cnt_o, miss_cnt_o     accepted / dropped trigger counts, saturating
//
// state   | meaning
// IDLE    | waiting for a trigger edge
// DELAY   | counting down the trigger-to-window delay
// PULSE   | actuation window open
// HOLDOFF | dead time after the window
module red_pitaya_fads_sorter
  import fads_pkg::*;
#(
  parameter int TW = TW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          adc_clk_i,
  input  logic          adc_rst_i,
  input  logic          sort_trig_i,
  input  logic          enable_i,
  input  logic [TW-1:0] delay_i,
  input  logic [TW-1:0] width_i,
  input  logic [TW-1:0] holdoff_i,
  input  logic          clr_cnt_i,
  output logic          asg_trig_o,
  output logic          sort_gate_o,
  output logic          busy_o,
  output logic [CW-1:0] sort_cnt_o,
  output logic [CW-1:0] miss_cnt_o
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [1:0]    state, state_nxt;
  logic          trig_q;
  logic          trig_edge;
  logic [TW-1:0] width_m1_q;
  logic [TW-1:0] holdoff_q;
  logic [TW-1:0] width_m1_in;
  logic          accept;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic [CW-1:0] sort_cnt;

  assign trig_edge   = sort_trig_i & ~trig_q;
  // A zero width still opens the window for one cycle.
  assign width_m1_in = (width_i == '0) ? '0 : width_i - TW'(1);

  // The timer is loaded with (duration - 1) on entry, so a state lasts
  // exactly its programmed number of cycles and leaves on the zero flag.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    accept    = 1'b0;
    if (!enable_i) begin
      state_nxt = ST_IDLE;
      tmr_load  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig_edge) begin
            accept   = 1'b1;
            tmr_load = 1'b1;
            if (delay_i != '0) begin
              state_nxt = ST_DELAY;
              tmr_val   = delay_i - TW'(1);
            end else begin
              state_nxt = ST_PULSE;
              tmr_val   = width_m1_in;
            end
          end
        end
        ST_DELAY: begin
          if (tmr_zero) begin
            state_nxt = ST_PULSE;
            tmr_load  = 1'b1;
            tmr_val   = width_m1_q;
          end
        end
        ST_PULSE: begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            if (holdoff_q != '0) begin
              state_nxt = ST_HOLDOFF;
              tmr_val   = holdoff_q - TW'(1);
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
        default: begin
          if (tmr_zero) begin
            state_nxt = ST_IDLE;
            tmr_load  = 1'b1;
          end
        end
      endcase
    end
  end

  fads_down_timer #(.TW(TW)) u_timer (
    .clk      (adc_clk_i),
    .rst      (adc_rst_i),
    .load     (tmr_load),
    .en       (1'b1),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      state       <= ST_IDLE;
      trig_q      <= 1'b0;
      width_m1_q  <= '0;
      holdoff_q   <= '0;
      sort_gate_o <= 1'b0;
      asg_trig_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_nxt;
      trig_q      <= sort_trig_i;
      if (accept) begin
        width_m1_q <= width_m1_in;
        holdoff_q  <= holdoff_i;
      end
      // Outputs are registered from the next state so they line up with it.
      sort_gate_o <= (state_nxt == ST_PULSE);
      asg_trig_o  <= (state_nxt == ST_PULSE) && (state != ST_PULSE);
      busy_o      <= (state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i)
      sort_cnt <= '0;
    else if (clr_cnt_i)
      sort_cnt <= '0;
    else if (accept)
      sort_cnt <= CW'(sat_inc(64'(sort_cnt), 64'(CNT_MAX)));
  end

  assign sort_cnt_o = sort_cnt;

`ifdef FADS_MISS_CNT_EN
  logic          miss_evt;
  logic [CW-1:0] miss_cnt;

  // Disabled edges are not misses; they are simply ignored.
  assign miss_evt = trig_edge && enable_i && (state != ST_IDLE);

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i)
      miss_cnt <= '0;
    else if (clr_cnt_i)
      miss_cnt <= '0;
    else if (miss_evt)
      miss_cnt <= CW'(sat_inc(64'(miss_cnt), 64'(CNT_MAX)));
  end

  assign miss_cnt_o = miss_cnt;
`else
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_red_pitaya_fads_sorter.sv
module tb_red_pitaya_fads_sorter;

  localparam int TW = 24;
  localparam int CW = 4;
`ifdef FADS_MISS_CNT_EN
  localparam int MISS_ON = 1;
`else
  localparam int MISS_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          trig;
  logic          enable;
  logic [TW-1:0] delay;
  logic [TW-1:0] width;
  logic [TW-1:0] holdoff;
  logic          clr_cnt;
  logic          asg_trig;
  logic          sort_gate;
  logic          busy;
  logic [CW-1:0] sort_cnt;
  logic [CW-1:0] miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  red_pitaya_fads_sorter #(.TW(TW), .CW(CW)) dut (
    .adc_clk_i   (clk),
    .adc_rst_i   (rst),
    .sort_trig_i (trig),
    .enable_i    (enable),
    .delay_i     (delay),
    .width_i     (width),
    .holdoff_i   (holdoff),
    .clr_cnt_i   (clr_cnt),
    .asg_trig_o  (asg_trig),
    .sort_gate_o (sort_gate),
    .busy_o      (busy),
    .sort_cnt_o  (sort_cnt),
    .miss_cnt_o  (miss_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic g, input logic a, input logic b);
    check_val({tag, " gate"}, 32'(sort_gate), 32'(g));
    check_val({tag, " asg"},  32'(asg_trig),  32'(a));
    check_val({tag, " busy"}, 32'(busy),      32'(b));
  endtask

  initial begin
    int gate_hi;
    int gate_rise;
    int asg_hi;
    logic gate_prev;

    rst = 1'b1; trig = 1'b0; enable = 1'b1; clr_cnt = 1'b0;
    delay = '0; width = '0; holdoff = '0;

    // Reset state
    tick(); tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    check_val("reset sort_cnt", 32'(sort_cnt), 0);
    check_val("reset miss_cnt", 32'(miss_cnt), 0);
    rst = 1'b0;
    tick();

    // Timing: D=10 W=5 H=20, trigger held 50 cycles; width changed mid-run
    // must not affect the window already accepted.
    clear_counters();
    delay = 10; width = 5; holdoff = 20;
    trig = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (i == 2) width = 1;
      check_outs($sformatf("timing c%0d", i),
                 (i >= 10 && i <= 14), (i == 10), (i <= 34));
      if (i == 49) trig = 1'b0;
    end
    width = 5;
    tick();
    check_val("timing sort_cnt", 32'(sort_cnt), 1);
    check_val("timing miss_cnt", 32'(miss_cnt), 0);

    // Zero config: one-cycle window right after acceptance
    delay = 0; width = 0; holdoff = 0;
    trig = 1'b1;
    tick();
    check_outs("zero c0", 1'b1, 1'b1, 1'b1);
    trig = 1'b0;
    tick();
    check_outs("zero c1", 1'b0, 1'b0, 1'b0);
    check_val("zero sort_cnt", 32'(sort_cnt), 2);

    // Busy drops: three 1-cycle pulses 3 cycles apart
    clear_counters();
    delay = 4; width = 4; holdoff = 10;
    gate_hi = 0; gate_rise = 0; gate_prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      trig = (i == 0 || i == 3 || i == 6);
      tick();
      if (sort_gate) gate_hi++;
      if (sort_gate && !gate_prev) gate_rise++;
      gate_prev = sort_gate;
    end
    check_val("drops gate windows", 32'(gate_rise), 1);
    check_val("drops gate cycles", 32'(gate_hi), 4);
    check_val("drops sort_cnt", 32'(sort_cnt), 1);
    check_val("drops miss_cnt", 32'(miss_cnt), 2 * MISS_ON);
    check_val("drops idle", 32'(busy), 0);

    // Edge on the last HOLDOFF cycle is missed; the next one is accepted
    clear_counters();
    delay = 0; width = 1; holdoff = 2;
    for (int i = 0; i < 6; i++) begin
      trig = (i == 0 || i == 3 || i == 5);
      tick();
      if (i == 3) check_val("lastho busy", 32'(busy), 0);
      if (i == 5) check_outs("lastho accept", 1'b1, 1'b1, 1'b1);
    end
    trig = 1'b0;
    tick(); tick(); tick(); tick();
    check_val("lastho sort_cnt", 32'(sort_cnt), 2);
    check_val("lastho miss_cnt", 32'(miss_cnt), MISS_ON);

    // Abort two cycles into PULSE, then re-enable
    clear_counters();
    delay = 2; width = 8; holdoff = 5;
    for (int i = 0; i < 4; i++) begin
      trig = (i == 0);
      tick();
    end
    check_outs("abort in pulse", 1'b1, 1'b0, 1'b1);
    enable = 1'b0;
    tick();
    check_outs("abort c1", 1'b0, 1'b0, 1'b0);
    trig = 1'b1;
    tick();
    check_outs("abort disabled edge", 1'b0, 1'b0, 1'b0);
    trig = 1'b0;
    tick();
    check_val("abort sort_cnt", 32'(sort_cnt), 1);
    check_val("abort miss_cnt", 32'(miss_cnt), 0);
    enable = 1'b1;
    tick();
    trig = 1'b1;
    tick();
    check_outs("reen accept", 1'b0, 1'b0, 1'b1);
    check_val("reen sort_cnt", 32'(sort_cnt), 2);
    trig = 1'b0;
    tick();
    check_outs("reen delay", 1'b0, 1'b0, 1'b1);
    tick();
    check_outs("reen pulse", 1'b1, 1'b1, 1'b1);
    repeat (20) tick();
    check_val("reen done", 32'(busy), 0);

    // Async reset between edges during DELAY
    clear_counters();
    delay = 10; width = 3; holdoff = 3;
    trig = 1'b1;
    tick(); tick(); tick();
    check_val("rst pre busy", 32'(busy), 1);
    #3;
    rst = 1'b1;
    #1;
    check_outs("rst async", 1'b0, 1'b0, 1'b0);
    check_val("rst sort_cnt", 32'(sort_cnt), 0);
    check_val("rst miss_cnt", 32'(miss_cnt), 0);
    trig = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    gate_hi = 0; asg_hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sort_gate) gate_hi++;
      if (asg_trig) asg_hi++;
    end
    check_val("rst post gate", 32'(gate_hi), 0);
    check_val("rst post asg", 32'(asg_hi), 0);

    // Saturation at 15 and clear winning over an acceptance
    delay = 0; width = 0; holdoff = 0;
    for (int n = 1; n <= 20; n++) begin
      trig = 1'b1;
      tick();
      trig = 1'b0;
      tick();
      if (n == 7) check_val("sat mid", 32'(sort_cnt), 7);
    end
    check_val("sat hold", 32'(sort_cnt), 15);
    trig = 1'b1;
    clr_cnt = 1'b1;
    tick();
    check_val("clr wins", 32'(sort_cnt), 0);
    check_val("clr accepted", 32'(busy), 1);
    clr_cnt = 1'b0;
    trig = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
